// File: rtl/reg_dump_streamer.sv
// Snapshots the register-file tap on Trigger and streams it out as a byte frame.
// Define REG_DUMP_CHECKSUM_EN to append a modulo-2^REG_W checksum byte to each frame.
module reg_dump_streamer #(
    parameter int NUM_REGS = 8,
    parameter int REG_W = 8,
    parameter logic [REG_W-1:0] HEADER = 8'hA5
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Trigger,
    input  logic [NUM_REGS*REG_W-1:0] RegFlat,
    output logic [REG_W-1:0]          Out_data,
    output logic                      Out_valid,
    input  logic                      Out_ready,
    output logic                      Busy,
    output logic                      Done,
    output logic                      TrigDropped
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_REGS - 1);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR  = 3'd1;
    localparam logic [2:0] REGS = 3'd2;
    localparam logic [2:0] CSUM = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [IDX_W-1:0] idx;
    logic [REG_W-1:0] snap [NUM_REGS];
    logic             xfer;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [REG_W-1:0] csum;
`endif

    assign xfer = Out_valid & Out_ready;

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (Trigger) state_nxt = HDR;
            HDR:  if (xfer) state_nxt = REGS;
            REGS: begin
                if (xfer && idx == LAST) begin
`ifdef REG_DUMP_CHECKSUM_EN
                    state_nxt = CSUM;
`else
                    state_nxt = FIN;
`endif
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: if (xfer) state_nxt = FIN;
`endif
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Data is forced to zero outside the byte-carrying states
    always_comb begin
        Out_valid = 1'b0;
        Out_data  = '0;
        unique case (state)
            HDR: begin
                Out_valid = 1'b1;
                Out_data  = HEADER;
            end
            REGS: begin
                Out_valid = 1'b1;
                Out_data  = snap[idx];
            end
`ifdef REG_DUMP_CHECKSUM_EN
            CSUM: begin
                Out_valid = 1'b1;
                Out_data  = csum;
            end
`endif
            default: begin
                Out_valid = 1'b0;
                Out_data  = '0;
            end
        endcase
    end

    assign Busy        = (state != IDLE);
    assign Done        = (state == FIN);
    assign TrigDropped = Trigger & (state != IDLE);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            idx   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                snap[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            if (state == IDLE && Trigger) begin
                idx <= '0;
                for (int i = 0; i < NUM_REGS; i++) begin
                    snap[i] <= RegFlat[i*REG_W +: REG_W];
                end
            end else if (state == HDR && xfer) begin
                idx <= '0;
            end else if (state == REGS && xfer && idx != LAST) begin
                idx <= idx + IDX_W'(1);
            end
        end
    end

`ifdef REG_DUMP_CHECKSUM_EN
    // Running sum of every byte already accepted by the sink
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            csum <= '0;
        end else if (state == IDLE && Trigger) begin
            csum <= '0;
        end else if (xfer && (state == HDR || state == REGS)) begin
            csum <= csum + Out_data;
        end
    end
`endif

endmodule
